// File: rtl/pipeline_pkg.sv
// Shared types for the five-stage core pipeline registers.
//   alu_op_e   : ALU operation codes driven onto the ALU sel bus
//   fwd_sel_e  : which source an EX operand was taken from
//   id_ex_t    : every field held in the ID/EX pipeline register
//   NOP_ID_EX  : all-zero bubble (invalid, no side effects)
package pipeline_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        AND  = 3'b010,
        OR   = 3'b011,
        SLT  = 3'b100,
        BSUB = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        alu_op_e          alu_sel;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             branch;
    } id_ex_t;

    localparam id_ex_t NOP_ID_EX = '0;

endpackage

// File: rtl/forward_unit.sv
// EX-input forwarding mux for one source register.
//   rs, rs_data            : registered source index and its register-file value
//   mem_reg_write/rd/result: EX/MEM forwarding source (highest priority)
//   wb_reg_write/rd/result : MEM/WB forwarding source
//   value                  : selected operand value
//   sel                    : which source was selected
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rs_data,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  value,
    output fwd_sel_e         sel
);

    always_comb begin
        sel   = FWD_REG;
        value = rs_data;
        // x0 is hard-wired zero, so a producer targeting x0 is never forwarded.
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
            sel   = FWD_MEM;
            value = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
            sel   = FWD_WB;
            value = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-operand forwarding and load-use hazard detection.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   id_*              : decoded instruction from the decode stage
//   flush             : squash the decode slot (taken branch)
//   mem_*, wb_*       : forwarding sources from EX/MEM and MEM/WB
//   stall             : hold PC and IF/ID this cycle (combinational)
//   ex_*              : registered instruction and forwarded ALU operands
module id_ex_stage
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [2:0]       id_alu_sel,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_inp_A,
    output logic [XLEN-1:0]  ex_inp_B,
    output logic [2:0]       ex_alu_sel,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch
);

    id_ex_t          q;
    id_ex_t          d;
    logic            hazard;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    fwd_sel_e        fwd_sel_a;
    fwd_sel_e        fwd_sel_b;

    // Load-use: the load in EX only has its data after MEM, so a dependent
    // instruction in ID must wait one cycle. A flush kills that instruction anyway.
    always_comb begin
        hazard = (id_use_rs1 && (id_rs1 == q.rd)) || (id_use_rs2 && (id_rs2 == q.rd));
        stall  = q.valid && q.mem_read && (q.rd != '0) && id_valid && hazard && !flush;
    end

    always_comb begin
        d = NOP_ID_EX;
        if (!flush && !stall) begin
            d.valid      = id_valid;
            d.pc         = id_pc;
            d.rs1_data   = id_rs1_data;
            d.rs2_data   = id_rs2_data;
            d.imm        = id_imm;
            d.rs1        = id_rs1;
            d.rs2        = id_rs2;
            d.rd         = id_rd;
            d.alu_sel    = alu_op_e'(id_alu_sel);
            d.alu_src    = id_alu_src;
            // Gating with valid keeps bubbles free of architectural side effects.
            d.reg_write  = id_reg_write  & id_valid;
            d.mem_read   = id_mem_read   & id_valid;
            d.mem_write  = id_mem_write  & id_valid;
            d.mem_to_reg = id_mem_to_reg & id_valid;
            d.branch     = id_branch     & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= NOP_ID_EX;
        end else begin
            q <= d;
        end
    end

    forward_unit u_fwd_rs1 (
        .rs            (q.rs1),
        .rs_data       (q.rs1_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .value         (fwd_a),
        .sel           (fwd_sel_a)
    );

    forward_unit u_fwd_rs2 (
        .rs            (q.rs2),
        .rs_data       (q.rs2_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .value         (fwd_b),
        .sel           (fwd_sel_b)
    );

    // Sanity: an operand marked as coming from the register file is the registered value.
    always_comb begin
        if (fwd_sel_a == FWD_REG) assert (fwd_a == q.rs1_data);
        if (fwd_sel_b == FWD_REG) assert (fwd_b == q.rs2_data);
    end

    assign ex_valid      = q.valid;
    assign ex_inp_A      = fwd_a;
    assign ex_inp_B      = q.alu_src ? q.imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_alu_sel    = q.alu_sel;
    assign ex_pc         = q.pc;
    assign ex_imm        = q.imm;
    assign ex_rd         = q.rd;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_mem_to_reg = q.mem_to_reg;
    assign ex_branch     = q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies inputs each cycle, predicts the
// outputs from a behavioural model of the EX slot and queues them; a monitor compares
// on the falling edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [2:0]  id_alu_sel;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_inp_A, ex_inp_B, ex_store_data, ex_pc, ex_imm;
    logic [2:0]  ex_alu_sel;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_alu_sel    (id_alu_sel),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_branch     (id_branch),
        .flush         (flush),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_inp_A      (ex_inp_A),
        .ex_inp_B      (ex_inp_B),
        .ex_alu_sel    (ex_alu_sel),
        .ex_store_data (ex_store_data),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch)
    );

    // Model of the instruction occupying EX. ctrl = {reg_write, mem_read, mem_write,
    // mem_to_reg, branch}. "loose" marks a slot captured with id_valid=0, whose
    // operand-B select and ALU op are not checked.
    typedef struct {
        bit          known;
        bit          valid;
        bit          loose;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  r1, r2, rd, ctrl;
        logic [2:0]  sel;
        bit          src;
    } slot_t;

    typedef struct {
        bit          full;
        logic        stall, valid;
        logic [31:0] a, b, sd, pc, imm;
        logic [4:0]  rd, ctrl;
        logic [2:0]  sel;
    } exp_t;

    exp_t  sb[$];
    slot_t slot;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value an EX operand should carry: newest producer wins, x0 is always its own value.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
        if (r != 0 && mem_reg_write && mem_rd == r) return mem_result;
        if (r != 0 && wb_reg_write && wb_rd == r) return wb_result;
        return d;
    endfunction

    task automatic step();
        exp_t  e;
        slot_t n;
        bit    dep;
        bit    stl = 1'b0;
        if (slot.known) begin
            dep = (id_use_rs1 && id_rs1 == slot.rd) || (id_use_rs2 && id_rs2 == slot.rd);
            stl = slot.valid && slot.ctrl[3] && slot.rd != 0 && id_valid && dep && !flush;
            e.full  = !slot.loose;
            e.stall = stl;
            e.valid = slot.valid;
            e.a     = operand(slot.r1, slot.d1);
            e.sd    = operand(slot.r2, slot.d2);
            e.b     = slot.src ? slot.imm : e.sd;
            e.pc    = slot.pc;
            e.imm   = slot.imm;
            e.rd    = slot.rd;
            e.ctrl  = slot.ctrl;
            e.sel   = slot.sel;
            sb.push_back(e);
        end
        n = '{default: 0};
        n.known = 1'b1;
        if (!(rst || flush || stl)) begin
            n.valid = id_valid;
            n.loose = !id_valid;
            n.pc    = id_pc;
            n.d1    = id_rs1_data;
            n.d2    = id_rs2_data;
            n.imm   = id_imm;
            n.r1    = id_rs1;
            n.r2    = id_rs2;
            n.rd    = id_rd;
            n.sel   = id_alu_sel;
            n.src   = id_alu_src;
            n.ctrl  = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
                                  id_branch} : 5'd0;
        end
        @(posedge clk);
        #1;
        slot = n;
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0;
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_alu_sel = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic rand_id();
        id_valid      = ($urandom_range(0, 9) != 0);
        id_pc         = $urandom;
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_rs1        = 5'($urandom_range(0, 7));
        id_rs2        = 5'($urandom_range(0, 7));
        id_rd         = 5'($urandom_range(0, 7));
        id_use_rs1    = 1'($urandom_range(0, 1));
        id_use_rs2    = 1'($urandom_range(0, 1));
        id_alu_sel    = 3'($urandom_range(0, 5));
        id_alu_src    = 1'($urandom_range(0, 1));
        id_reg_write  = 1'($urandom_range(0, 1));
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = 1'($urandom_range(0, 1));
        id_mem_to_reg = 1'($urandom_range(0, 1));
        id_branch     = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_fwd();
        mem_reg_write = 1'($urandom_range(0, 1));
        mem_rd        = 5'($urandom_range(0, 7));
        mem_result    = $urandom;
        wb_reg_write  = 1'($urandom_range(0, 1));
        wb_rd         = 5'($urandom_range(0, 7));
        wb_result     = $urandom;
    endtask

    // Plain ALU instruction in ID with the given sources and destination.
    task automatic id_alu(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = 1; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_use_rs1 = 1; id_use_rs2 = 1; id_reg_write = 1;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        id_alu_sel = 3'b000; id_alu_src = 0; id_pc = 32'h100; id_imm = 32'h4;
    endtask

    // Monitor: compare every queued prediction against the outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", stall, e.stall);
                chk("ex_valid", ex_valid, e.valid);
                chk("ex_inp_A", ex_inp_A, e.a);
                chk("ex_store_data", ex_store_data, e.sd);
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_rd", ex_rd, e.rd);
                chk("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                                ex_branch}, e.ctrl);
                if (e.full) begin
                    chk("ex_inp_B", ex_inp_B, e.b);
                    chk("ex_alu_sel", ex_alu_sel, e.sel);
                end
            end
        end
    end

    initial begin
        slot = '{default: 0};
        clear_inputs();

        // Reset for two cycles with live-looking decode inputs.
        rand_id(); rand_fwd(); id_valid = 1; rst = 1;
        step();
        rand_id(); rand_fwd(); id_valid = 1; rst = 1;
        step();

        // Forward priority: x5 in EX, both MEM and WB target x5.
        clear_inputs();
        id_alu(5'd5, 5'd6, 5'd9); id_rs1_data = 32'h1;
        step();
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'h10;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'h20;
        step();                     // MEM wins; same add is re-captured
        mem_reg_write = 0;
        step();                     // WB now selected

        // x0 guard on rs2.
        clear_inputs();
        id_alu(5'd1, 5'd0, 5'd3); id_rs2_data = 32'h0;
        step();
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'h55;
        wb_reg_write = 1; wb_rd = 0; wb_result = 32'h66;
        step();

        // Load-use: lw x7 then add using x7 as rs2.
        for (int fl = 0; fl < 2; fl++) begin
            clear_inputs();
            id_valid = 1; id_rd = 7; id_rs1 = 2; id_use_rs1 = 1; id_imm = 32'h8;
            id_alu_src = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
            step();                 // lw captured
            clear_inputs();
            id_alu(5'd3, 5'd7, 5'd8);
            flush = 1'(fl);         // second pass: flush squashes the dependent add
            step();                 // lw in EX: stall unless flushed
            flush = 0;
            step();                 // bubble in EX, add still in ID
            id_valid = 0;
            wb_reg_write = 1; wb_rd = 7; wb_result = 32'hCAFE_0007;
            step();                 // add in EX with load value forwarded
        end

        // Immediate operand with rs2 forwarded from WB.
        clear_inputs();
        id_alu(5'd4, 5'd9, 5'd10);
        id_imm = 32'hFFFF_FFFC; id_alu_src = 1; id_alu_sel = 3'b101;
        step();
        id_valid = 0;
        wb_reg_write = 1; wb_rd = 9; wb_result = 32'h99;
        step();

        // Random traffic, biased toward small register numbers to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            flush = ($urandom_range(0, 11) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            step();
        end

        // Drain: every prediction must have been consumed by the monitor.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
